// File: rtl/v_key_event.sv
// v_key_event: classifies a debounced key level into single-click,
// double-click and long-press events, timed on a 1 ms tick.
module v_key_event #(
    parameter int CLK_PER_MS = 50000,
    parameter int LONG_MS    = 1000,
    parameter int DCLICK_MS  = 300
) (
    input  logic clock,
    input  logic reset,
    input  logic SSW,
    output logic pressed,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int              TW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [TW-1:0]   TICK_LAST  = TW'(CLK_PER_MS - 1);
    localparam logic [15:0]     LONG_LAST  = 16'(LONG_MS - 1);
    localparam logic [15:0]     DCLK_LAST  = 16'(DCLICK_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_GAP    = 3'd2,
        S_PRESS2 = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    logic          r_ssw_d;
    logic [TW-1:0] r_tick_cnt;
    logic [15:0]   r_ms_cnt;
    state_t        r_state;
    state_t        w_next;

    logic w_rise;
    logic w_fall;
    logic w_tick;
    logic w_long_hit;
    logic w_dclk_hit;

    logic w_single_nxt;
    logic w_double_nxt;
    logic w_long_nxt;

    logic r_single;
    logic r_double;
    logic r_long;
    logic r_busy;

    assign w_rise     = SSW & ~r_ssw_d;
    assign w_fall     = ~SSW & r_ssw_d;
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    // Timeouts only fire on the tick that would complete the interval.
    assign w_long_hit = w_tick && (r_ms_cnt == LONG_LAST);
    assign w_dclk_hit = w_tick && (r_ms_cnt == DCLK_LAST);

    // Delayed switch level, used for edge detection and as the pressed output.
    always_ff @(posedge clock) begin
        if (reset) r_ssw_d <= 1'b0;
        else       r_ssw_d <= SSW;
    end

    // Free-running 1 ms prescaler; the FSM never restarts it, so the first
    // tick after an event may arrive anywhere within the next millisecond.
    always_ff @(posedge clock) begin
        if (reset)       r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    // Milliseconds spent in the current state; restarts on any state change.
    always_ff @(posedge clock) begin
        if (reset)
            r_ms_cnt <= '0;
        else if (w_next != r_state)
            r_ms_cnt <= '0;
        else if (w_tick && (r_ms_cnt != 16'hFFFF))
            r_ms_cnt <= r_ms_cnt + 16'd1;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; switch edges are tested before timeouts so an edge
    // coinciding with a timeout tick wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_next = S_PRESS1;
            end
            S_PRESS1: begin
                if (w_fall)          w_next = S_GAP;
                else if (w_long_hit) w_next = S_LONG;
            end
            S_GAP: begin
                if (w_rise)          w_next = S_PRESS2;
                else if (w_dclk_hit) w_next = S_IDLE;
            end
            S_PRESS2: begin
                if (w_fall)          w_next = S_IDLE;
                else if (w_long_hit) w_next = S_LONG;
            end
            S_LONG: begin
                if (w_fall) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Event decode for the transition being taken this cycle; the priority
    // mirrors the next-state logic so at most one event is raised.
    always_comb begin
        w_single_nxt = 1'b0;
        w_double_nxt = 1'b0;
        w_long_nxt   = 1'b0;
        case (r_state)
            S_PRESS1: begin
                if (!w_fall && w_long_hit) w_long_nxt = 1'b1;
            end
            S_GAP: begin
                if (!w_rise && w_dclk_hit) w_single_nxt = 1'b1;
            end
            S_PRESS2: begin
                if (w_fall)          w_double_nxt = 1'b1;
                else if (w_long_hit) w_long_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered event pulses and busy flag (busy follows the next state so it
    // rises together with the first non-IDLE state).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_single <= w_single_nxt;
            r_double <= w_double_nxt;
            r_long   <= w_long_nxt;
            r_busy   <= (w_next != S_IDLE);
        end
    end

    assign pressed      = r_ssw_d;
    assign single_click = r_single;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign busy         = r_busy;

endmodule

// File: tb/tb_v_key_event.sv
// tb_v_key_event: directed scenarios plus randomized press/release traffic,
// every cycle compared against a behavioural key-event model.
module tb_v_key_event;

    localparam int P   = 10;
    localparam int LMS = 20;
    localparam int DMS = 5;

    logic clock = 1'b0;
    logic reset;
    logic SSW;
    logic pressed, single_click, double_click, long_press, busy;

    always #5 clock = ~clock;

    v_key_event #(.CLK_PER_MS(P), .LONG_MS(LMS), .DCLICK_MS(DMS)) dut (
        .clock        (clock),
        .reset        (reset),
        .SSW          (SSW),
        .pressed      (pressed),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .busy         (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 first hold, 2 release gap, 3 second hold, 4 long hold.
    int   m_phase, m_ms, m_cyc;
    bit   m_prev, m_valid;
    logic e_pressed, e_single, e_double, e_long, e_busy;
    int   cnt_single, cnt_double, cnt_long;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit s);
        bit rise, fall, tick;
        int np;
        bit ps, pd, pl;
        if (r) begin
            m_prev = 0; m_phase = 0; m_ms = 0; m_cyc = 0;
            {e_pressed, e_single, e_double, e_long, e_busy} = '0;
            return;
        end
        rise = s && !m_prev;
        fall = !s && m_prev;
        tick = (m_cyc % P) == P - 1;
        np = m_phase; ps = 0; pd = 0; pl = 0;
        case (m_phase)
            0: if (rise) np = 1;
            1: if (fall) np = 2;
               else if (tick && m_ms == LMS - 1) begin np = 4; pl = 1; end
            2: if (rise) np = 3;
               else if (tick && m_ms == DMS - 1) begin np = 0; ps = 1; end
            3: if (fall) begin np = 0; pd = 1; end
               else if (tick && m_ms == LMS - 1) begin np = 4; pl = 1; end
            default: if (fall) np = 0;
        endcase
        if (np != m_phase)            m_ms = 0;
        else if (tick && m_ms < 65535) m_ms = m_ms + 1;
        m_phase   = np;
        m_cyc     = m_cyc + 1;
        m_prev    = s;
        e_pressed = s;
        e_single  = ps;
        e_double  = pd;
        e_long    = pl;
        e_busy    = (np != 0);
    endtask

    // One cycle: check current outputs at negedge, drive inputs, advance.
    task automatic step(input bit r, input bit s);
        if (m_valid) begin
            chk("pressed", pressed,      e_pressed);
            chk("single",  single_click, e_single);
            chk("double",  double_click, e_double);
            chk("long",    long_press,   e_long);
            chk("busy",    busy,         e_busy);
        end
        cnt_single += int'(single_click === 1'b1);
        cnt_double += int'(double_click === 1'b1);
        cnt_long   += int'(long_press === 1'b1);
        reset = r;
        SSW   = s;
        model_edge(r, s);
        if (r) m_valid = 1;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n, input bit s);
        for (int i = 0; i < n; i++) step(0, s);
    endtask

    task automatic clr_cnt();
        cnt_single = 0; cnt_double = 0; cnt_long = 0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; SSW = 1'b0; m_valid = 0;
        clr_cnt();
        @(negedge clock);
        step(1, 0); step(1, 0); step(1, 0);

        // Reset state
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_pulses",  single_click | double_click | long_press, 1'b0);
        run(5, 0);

        // Single click
        clr_cnt();
        run(50, 1); run(80, 0);
        chk("sc_single_cnt", cnt_single == 1, 1'b1);
        chk("sc_other_cnt",  (cnt_double + cnt_long) == 0, 1'b1);

        // Double click: pulse right after the second fall
        clr_cnt();
        run(40, 1); run(20, 0); run(40, 1); step(0, 0);
        chk("dc_latency", double_click, 1'b1);
        run(60, 0);
        chk("dc_double_cnt", cnt_double == 1, 1'b1);
        chk("dc_no_single",  cnt_single == 0, 1'b1);

        // Long press: one pulse, busy until one cycle after the fall
        clr_cnt();
        run(400, 1);
        chk("lp_busy_held", busy, 1'b1);
        step(0, 0);
        chk("lp_busy_drop", busy, 1'b0);
        run(60, 0);
        chk("lp_long_cnt",  cnt_long == 1, 1'b1);
        chk("lp_no_click",  (cnt_single + cnt_double) == 0, 1'b1);

        // Tie-break: fall on the same edge as the PRESS1 long timeout
        clr_cnt();
        step(0, 1);
        guard = 0;
        while (!(m_phase == 1 && (m_cyc % P) == P - 1 && m_ms == LMS - 1) && guard < 1000) begin
            step(0, 1);
            guard++;
        end
        chk("tb_found_tie", guard < 1000, 1'b1);
        step(0, 0);
        chk("tb_in_gap_busy", busy, 1'b1);
        run(80, 0);
        chk("tb_no_long",  cnt_long == 0, 1'b1);
        chk("tb_single",   cnt_single == 1, 1'b1);

        // Reset during the release gap aborts the pending single click
        clr_cnt();
        run(30, 1); run(10, 0);
        chk("rg_busy_gap", busy, 1'b1);
        step(1, 0);
        chk("rg_busy_rst", busy, 1'b0);
        run(80, 0);
        chk("rg_no_single", cnt_single == 0, 1'b1);

        // Reset released with the key held: counts as a new press
        clr_cnt();
        step(1, 1); step(1, 1);
        step(0, 1); step(0, 1);
        chk("rh_pressed", pressed, 1'b1);
        chk("rh_busy",    busy,    1'b1);
        run(28, 1); run(80, 0);
        chk("rh_single", cnt_single == 1, 1'b1);

        // Randomized traffic with occasional resets
        for (int ep = 0; ep < 60; ep++) begin
            run($urandom_range(250, 1), 1);
            if ($urandom_range(19, 0) == 0) step(1, $urandom_range(1, 0) == 1);
            run($urandom_range(80, 1), 0);
        end
        run(100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
